// File: rtl/fds_pkg.sv
// -----------------------------------------------------------------------------
// fds_pkg
// Shared definitions for the FDS audio register-file initiator:
//   - register offsets inside the 0x4040..0x408A window
//   - host command opcode enum
//   - sequencer state enum
//   - address composition helper (base OR offset)
// No ports; imported by fds_m2_edge users and fds_reg_sequencer.
// -----------------------------------------------------------------------------
package fds_pkg;

    // Register offsets (low byte of the CPU address)
    localparam logic [7:0] FDS_WAVE_BASE = 8'h40;   // wavetable RAM 0x40..0x7F
    localparam logic [7:0] FDS_MOD_CTRL  = 8'h87;   // mod freq high / halt (bit7)
    localparam logic [7:0] FDS_MOD_TBL   = 8'h88;   // mod table append port
    localparam logic [7:0] FDS_MASTER    = 8'h89;   // master volume / wave write gate (bit7)

    // Terminal table indices
    localparam logic [5:0] WAVE_LAST_IDX = 6'd63;
    localparam logic [5:0] MOD_LAST_IDX  = 6'd31;

    typedef enum logic [1:0] {
        CMD_SINGLE = 2'd0,
        CMD_WAVE   = 2'd1,
        CMD_MOD    = 2'd2,
        CMD_RSVD   = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SINGLE = 3'd1,
        ST_W_EN   = 3'd2,
        ST_W_DATA = 3'd3,
        ST_W_DIS  = 3'd4,
        ST_M_EN   = 3'd5,
        ST_M_DATA = 3'd6,
        ST_M_FIN  = 3'd7
    } seq_state_e;

    // Full 16-bit register address from the upper base and an 8-bit offset
    function automatic logic [15:0] fds_reg_addr(input logic [15:0] base,
                                                 input logic [7:0]  offset);
        return base | {8'h00, offset};
    endfunction

endpackage

// File: rtl/fds_m2_edge.sv
// -----------------------------------------------------------------------------
// fds_m2_edge
// Rising-edge detector for the CPU M2 phase, shared by M2-timed blocks.
// The previous-level register resets high so that an M2 already high when
// reset is released is not reported as a rising edge.
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   m2       in  CPU M2 phase
//   m2_rise  out 1 in the clk cycle where m2 is high and was low last cycle
// -----------------------------------------------------------------------------
module fds_m2_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic m2,
    output logic m2_rise
);

    logic old_m2_r;

    // Previous-cycle M2 level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            old_m2_r <= 1'b1;
        end else begin
            old_m2_r <= m2;
        end
    end

    assign m2_rise = m2 & ~old_m2_r;

endmodule

// File: rtl/fds_reg_sequencer.sv
// -----------------------------------------------------------------------------
// fds_reg_sequencer
// Bus-side initiator for the FDS audio register file. Takes host commands and
// issues one register write per M2 rising edge, hardware-sequencing the
// 66-write wavetable upload and the 34-write mod-table upload.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   m2                      CPU M2 phase (same signal the audio block sees)
//   cmd_valid/cmd_ready     command handshake
//   cmd_op/addr/data        0=single write, 1=wave upload, 2=mod upload, 3=drop
//   tbl_sel                 0=wave table source, 1=mod table source
//   tbl_rd_addr/tbl_rd_data table source read port (TBL_RD_LATENCY cycles)
//   busy                    command in progress
//   wr/addr_out/data_out    write port to the audio block
// A write is presented with wr=1 and held until the first cycle with an M2
// rising edge (the commit cycle); the next write appears the cycle after.
// -----------------------------------------------------------------------------
module fds_reg_sequencer
    import fds_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR      = 16'h4000,
    parameter int unsigned TBL_RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m2,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic        tbl_sel,
    output logic [5:0]  tbl_rd_addr,
    input  logic [5:0]  tbl_rd_data,
    output logic        busy,
    output logic        wr,
    output logic [15:0] addr_out,
    output logic [7:0]  data_out
);

    // Wait count value on which table data is valid (latency 1..3)
    localparam logic [1:0] LAT_LAST = 2'(TBL_RD_LATENCY - 1);

    seq_state_e  state_r,    state_s;
    logic [5:0]  idx_r,      idx_s;
    logic [1:0]  lat_cnt_r,  lat_cnt_s;
    logic        wr_r,       wr_s;
    logic [15:0] addr_r,     addr_s;
    logic [7:0]  data_r,     data_s;
    logic        tbl_sel_r,  tbl_sel_s;
    logic        busy_r,     busy_s;
    logic [7:0]  cmd_data_r, cmd_data_s;

    logic        m2_rise_s;
    logic        commit_s;
    logic        accept_s;
    logic        idle_ready_s;
    logic        is_mod_s;
    logic [5:0]  last_idx_s;

    fds_m2_edge u_m2_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .m2      (m2),
        .m2_rise (m2_rise_s)
    );

    assign idle_ready_s = (state_r == ST_IDLE) && !wr_r;
    assign accept_s     = cmd_valid && idle_ready_s;
    assign commit_s     = wr_r && m2_rise_s;
    assign is_mod_s     = (state_r == ST_M_DATA);
    assign last_idx_s   = is_mod_s ? MOD_LAST_IDX : WAVE_LAST_IDX;

    // Next-state, write-port and table-index logic
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        lat_cnt_s  = lat_cnt_r;
        wr_s       = wr_r;
        addr_s     = addr_r;
        data_s     = data_r;
        tbl_sel_s  = tbl_sel_r;
        cmd_data_s = cmd_data_r;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cmd_data_s = cmd_data;
                    case (cmd_op_e'(cmd_op))
                        CMD_SINGLE: begin
                            state_s = ST_SINGLE;
                            wr_s    = 1'b1;
                            addr_s  = fds_reg_addr(BASE_ADDR, cmd_addr);
                            data_s  = cmd_data;
                        end
                        CMD_WAVE: begin
                            state_s = ST_W_EN;
                            wr_s    = 1'b1;
                            addr_s  = fds_reg_addr(BASE_ADDR, FDS_MASTER);
                            data_s  = {6'b10_0000, cmd_data[1:0]};
                        end
                        CMD_MOD: begin
                            state_s = ST_M_EN;
                            wr_s    = 1'b1;
                            addr_s  = fds_reg_addr(BASE_ADDR, FDS_MOD_CTRL);
                            data_s  = {4'b1000, cmd_data[3:0]};
                        end
                        default: begin
                            // Reserved opcode: consumed without any write
                            state_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_SINGLE, ST_W_DIS, ST_M_FIN: begin
                if (commit_s) begin
                    state_s = ST_IDLE;
                    wr_s    = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end

            ST_W_EN, ST_M_EN: begin
                if (commit_s) begin
                    // The read of entry 0 starts in the next cycle
                    state_s   = (state_r == ST_M_EN) ? ST_M_DATA : ST_W_DATA;
                    tbl_sel_s = (state_r == ST_M_EN);
                    idx_s     = 6'd0;
                    lat_cnt_s = 2'd0;
                    wr_s      = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end

            ST_W_DATA, ST_M_DATA: begin
                if (wr_r) begin
                    if (commit_s) begin
                        if (idx_r == last_idx_s) begin
                            // Closing control write follows directly, no table read
                            state_s = is_mod_s ? ST_M_FIN : ST_W_DIS;
                            wr_s    = 1'b1;
                            addr_s  = fds_reg_addr(BASE_ADDR,
                                                   is_mod_s ? FDS_MOD_CTRL : FDS_MASTER);
                            data_s  = is_mod_s ? cmd_data_r : {6'b00_0000, cmd_data_r[1:0]};
                        end else begin
                            idx_s     = idx_r + 6'd1;
                            lat_cnt_s = 2'd0;
                            wr_s      = 1'b0;
                        end
                    end else begin
                        wr_s = 1'b1;
                    end
                end else if (lat_cnt_r == LAT_LAST) begin
                    // Table data for idx_r is valid this cycle
                    wr_s = 1'b1;
                    if (is_mod_s) begin
                        addr_s = fds_reg_addr(BASE_ADDR, FDS_MOD_TBL);
                        data_s = {5'b0_0000, tbl_rd_data[2:0]};
                    end else begin
                        addr_s = fds_reg_addr(BASE_ADDR, FDS_WAVE_BASE + {2'b00, idx_r});
                        data_s = {2'b00, tbl_rd_data};
                    end
                end else begin
                    lat_cnt_s = lat_cnt_r + 2'd1;
                end
            end

            default: begin
                state_s = ST_IDLE;
                wr_s    = 1'b0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and registered output update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            idx_r      <= 6'd0;
            lat_cnt_r  <= 2'd0;
            wr_r       <= 1'b0;
            addr_r     <= 16'h0000;
            data_r     <= 8'h00;
            tbl_sel_r  <= 1'b0;
            busy_r     <= 1'b0;
            cmd_data_r <= 8'h00;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            lat_cnt_r  <= lat_cnt_s;
            wr_r       <= wr_s;
            addr_r     <= addr_s;
            data_r     <= data_s;
            tbl_sel_r  <= tbl_sel_s;
            busy_r     <= busy_s;
            cmd_data_r <= cmd_data_s;
        end
    end

    // Ready is forced low while reset is asserted
    assign cmd_ready   = idle_ready_s && reset_n;
    assign wr          = wr_r;
    assign addr_out    = addr_r;
    assign data_out    = data_r;
    assign tbl_sel     = tbl_sel_r;
    assign tbl_rd_addr = idx_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_fds_reg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fds_reg_sequencer
// Two sequencer instances: [0] table latency 1 with a 12-clk M2 period,
// [1] table latency 3 with a 4-clk M2 period. Each table source answers
// with data for the address presented LAT-1 cycles earlier. The expected
// commit stream is generated from the command semantics into a FIFO and
// compared against every write the DUT commits on an M2 rising edge.
// -----------------------------------------------------------------------------
module tb_fds_reg_sequencer;

    localparam int N = 2;
    localparam int LAT [N] = '{1, 3};
    localparam int PER [N] = '{12, 4};

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m2          [N];
    logic        cmd_valid   [N];
    logic        cmd_ready   [N];
    logic [1:0]  cmd_op      [N];
    logic [7:0]  cmd_addr    [N];
    logic [7:0]  cmd_data    [N];
    logic        tbl_sel     [N];
    logic [5:0]  tbl_rd_addr [N];
    logic [5:0]  tbl_rd_data [N];
    logic        busy        [N];
    logic        wr          [N];
    logic [15:0] addr_out    [N];
    logic [7:0]  data_out    [N];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        fds_reg_sequencer #(
            .BASE_ADDR      (16'h4000),
            .TBL_RD_LATENCY (LAT[g])
        ) u_dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .m2          (m2[g]),
            .cmd_valid   (cmd_valid[g]),
            .cmd_ready   (cmd_ready[g]),
            .cmd_op      (cmd_op[g]),
            .cmd_addr    (cmd_addr[g]),
            .cmd_data    (cmd_data[g]),
            .tbl_sel     (tbl_sel[g]),
            .tbl_rd_addr (tbl_rd_addr[g]),
            .tbl_rd_data (tbl_rd_data[g]),
            .busy        (busy[g]),
            .wr          (wr[g]),
            .addr_out    (addr_out[g]),
            .data_out    (data_out[g])
        );
    end

    // ---------------- table contents ----------------
    function automatic logic [5:0] wave_tbl(input int i);
        logic [5:0] v;
        v = 6'(i);
        return v ^ 6'h2A;
    endfunction

    // Upper bits are junk the sequencer must drop
    function automatic logic [5:0] mod_tbl(input int i);
        logic [5:0] v;
        v = 6'(i);
        return {3'b101, v[2:0]};
    endfunction

    function automatic logic [5:0] src_data(input logic sel, input logic [5:0] a);
        return sel ? mod_tbl(int'(a)) : wave_tbl(int'(a));
    endfunction

    logic [5:0] hist_a [N][2];
    logic       hist_s [N][2];

    // Address/select history for the delayed table source
    always @(posedge clk) begin
        for (int g = 0; g < N; g++) begin
            hist_a[g][0] <= tbl_rd_addr[g];
            hist_a[g][1] <= hist_a[g][0];
            hist_s[g][0] <= tbl_sel[g];
            hist_s[g][1] <= hist_s[g][0];
        end
    end

    // Table source: data for the address presented LAT-1 cycles ago
    always_comb begin
        for (int g = 0; g < N; g++) begin
            if (LAT[g] == 1) tbl_rd_data[g] = src_data(tbl_sel[g], tbl_rd_addr[g]);
            else             tbl_rd_data[g] = src_data(hist_s[g][LAT[g]-2], hist_a[g][LAT[g]-2]);
        end
    end

    // ---------------- M2 generation ----------------
    initial begin
        int ph [N];
        for (int g = 0; g < N; g++) begin
            ph[g] = 0;
            m2[g] = 1'b1;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int g = 0; g < N; g++) begin
                ph[g] = (ph[g] + 1) % PER[g];
                m2[g] = (ph[g] < PER[g] / 2);
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired, got timeout, required completion", name);
    endtask

    // ---------------- expected commit stream ----------------
    logic [23:0] exp_mem [N][256];
    int          wp [N];
    int          rp [N];

    task automatic push(input int g, input logic [15:0] a, input logic [7:0] d);
        exp_mem[g][wp[g] % 256] = {a, d};
        wp[g]++;
    endtask

    task automatic push_cmd(input int g, input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
        logic [5:0] t;
        case (op)
            2'd0: push(g, 16'h4000 | {8'h00, a}, d);
            2'd1: begin
                push(g, 16'h4089, 8'h80 | {6'd0, d[1:0]});
                for (int i = 0; i < 64; i++) push(g, 16'h4040 + 16'(i), {2'b00, wave_tbl(i)});
                push(g, 16'h4089, {6'd0, d[1:0]});
            end
            2'd2: begin
                push(g, 16'h4087, 8'h80 | {4'd0, d[3:0]});
                for (int i = 0; i < 32; i++) begin
                    t = mod_tbl(i);
                    push(g, 16'h4088, {5'd0, t[2:0]});
                end
                push(g, 16'h4087, d);
            end
            default: ;
        endcase
    endtask

    // ---------------- per-cycle compare ----------------
    logic        prev_m2     [N];
    logic        prev_wr     [N];
    logic        prev_commit [N];
    logic [15:0] prev_addr   [N];
    logic [7:0]  prev_data   [N];
    int          commits     [N];
    int          mod_wr      [N];
    logic [15:0] last_addr   [N];
    logic [7:0]  last_data   [N];
    logic [5:0]  wave_mem    [N][64];

    initial begin
        logic e;
        for (int g = 0; g < N; g++) begin
            wp[g] = 0; rp[g] = 0; commits[g] = 0; mod_wr[g] = 0;
            prev_m2[g] = 1'b1; prev_wr[g] = 1'b0; prev_commit[g] = 1'b0;
            last_addr[g] = 16'h0; last_data[g] = 8'h0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < N; g++) begin
                e = m2[g] & ~prev_m2[g];
                if (reset_n === 1'b1) begin
                    if (wr[g] && prev_wr[g] && !prev_commit[g])
                        check("write_held_stable", {8'h0, addr_out[g], data_out[g]},
                              {8'h0, prev_addr[g], prev_data[g]});
                    if (wr[g]) check("busy_during_write", busy[g], 1);
                    if (wr[g] && e) begin
                        if (rp[g] == wp[g]) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL unexpected_commit[%0d]: got %h=%h, required no write",
                                     g, addr_out[g], data_out[g]);
                        end else begin
                            check("commit_stream", {8'h0, addr_out[g], data_out[g]},
                                  {8'h0, exp_mem[g][rp[g] % 256]});
                            rp[g]++;
                        end
                        commits[g]++;
                        last_addr[g] = addr_out[g];
                        last_data[g] = data_out[g];
                        if (addr_out[g] >= 16'h4040 && addr_out[g] <= 16'h407F)
                            wave_mem[g][addr_out[g][5:0]] = data_out[g][5:0];
                        if (addr_out[g] == 16'h4088) mod_wr[g]++;
                    end
                    prev_wr[g]     = wr[g];
                    prev_commit[g] = wr[g] & e;
                    prev_addr[g]   = addr_out[g];
                    prev_data[g]   = data_out[g];
                end else begin
                    prev_wr[g]     = 1'b0;
                    prev_commit[g] = 1'b0;
                end
                prev_m2[g] = m2[g];
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input int g, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] d, input int budget, output int acc_cnt);
        bit got;
        got = 1'b0;
        acc_cnt = -1;
        @(posedge clk);
        #1;
        cmd_valid[g] = 1'b1;
        cmd_op[g]    = op;
        cmd_addr[g]  = a;
        cmd_data[g]  = d;
        for (int k = 0; k < budget && !got; k++) begin
            tick();
            if (cmd_ready[g]) got = 1'b1;
        end
        if (got) begin
            acc_cnt = commits[g];
            push_cmd(g, op, a, d);
        end else begin
            timeout("cmd_accept");
        end
        @(posedge clk);
        #1;
        cmd_valid[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g, input int budget, output int busy_cycles);
        busy_cycles = 0;
        tick();
        while (busy[g] && busy_cycles < budget) begin
            busy_cycles++;
            tick();
        end
        if (busy[g]) timeout("wait_idle");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int c, acc, bc, k;
        reset_n = 1'b0;
        for (int g = 0; g < N; g++) begin
            cmd_valid[g] = 1'b0; cmd_op[g] = 2'd0; cmd_addr[g] = 8'h00; cmd_data[g] = 8'h00;
        end
        repeat (3) tick();
        for (int g = 0; g < N; g++) begin
            check("rst_wr",          wr[g], 0);
            check("rst_addr_out",    addr_out[g], 0);
            check("rst_data_out",    data_out[g], 0);
            check("rst_busy",        busy[g], 0);
            check("rst_tbl_sel",     tbl_sel[g], 0);
            check("rst_tbl_rd_addr", tbl_rd_addr[g], 0);
            check("rst_cmd_ready",   cmd_ready[g], 0);
        end
        reset_n = 1'b1;
        tick();
        for (int g = 0; g < N; g++) check("ready_after_release", cmd_ready[g], 1);

        // Latency 3, 4-clk M2: one commit per edge, no skew
        c = commits[1];
        issue(1, 2'd1, 8'h00, 8'h01, 20, acc);
        wait_idle(1, 400, bc);
        check("lat3_wave_commits", commits[1] - c, 66);
        check("lat3_no_missed_edge", (bc <= 264), 1);
        check("lat3_last_write", {last_addr[1], last_data[1]}, {16'h4089, 8'h01});
        for (int i = 0; i < 64; i++) check("lat3_wave_readback", wave_mem[1][i], wave_tbl(i));

        // Single write
        c = commits[0];
        issue(0, 2'd0, 8'h82, 8'h5A, 20, acc);
        wait_idle(0, 100, bc);
        check("single_commits", commits[0] - c, 1);
        check("single_busy_len", (bc >= 1 && bc <= 12), 1);
        check("single_write", {last_addr[0], last_data[0]}, {16'h4082, 8'h5A});
        check("single_ready_back", cmd_ready[0], 1);

        // Wave upload
        c = commits[0];
        issue(0, 2'd1, 8'h00, 8'h02, 20, acc);
        wait_idle(0, 66 * 12 + 40, bc);
        check("wave_commits", commits[0] - c, 66);
        check("wave_last_write", {last_addr[0], last_data[0]}, {16'h4089, 8'h02});
        check("wave_mem_first", wave_mem[0][0], 6'h2A);
        check("wave_mem_last", wave_mem[0][63], 6'h15);
        for (int i = 0; i < 64; i++) check("wave_readback", wave_mem[0][i], wave_tbl(i));
        check("wave_tbl_sel", tbl_sel[0], 0);

        // Mod upload
        c = commits[0];
        issue(0, 2'd2, 8'h00, 8'h45, 20, acc);
        wait_idle(0, 34 * 12 + 40, bc);
        check("mod_commits", commits[0] - c, 34);
        check("mod_table_writes", mod_wr[0], 32);
        check("mod_ptr_wrapped", mod_wr[0] % 32, 0);
        check("mod_last_write", {last_addr[0], last_data[0]}, {16'h4087, 8'h45});
        check("mod_tbl_sel", tbl_sel[0], 1);

        // Reserved opcode: accepted, no writes
        c = commits[0];
        issue(0, 2'd3, 8'h11, 8'h22, 20, acc);
        check("rsvd_accepted", (acc >= 0), 1);
        repeat (30) tick();
        check("rsvd_commits", commits[0] - c, 0);
        check("rsvd_busy", busy[0], 0);
        check("rsvd_ready", cmd_ready[0], 1);

        // Back-pressure: command held across a whole wave upload
        c = commits[0];
        issue(0, 2'd1, 8'h00, 8'h03, 20, acc);
        issue(0, 2'd0, 8'h80, 8'hA5, 66 * 12 + 60, acc);
        check("bp_accept_after_wdis", acc - c, 66);
        wait_idle(0, 40, bc);
        check("bp_commits", commits[0] - c, 67);
        check("bp_single_write", {last_addr[0], last_data[0]}, {16'h4080, 8'hA5});

        // Reset in the middle of a wave upload
        c = commits[0];
        issue(0, 2'd1, 8'h00, 8'h01, 20, acc);
        for (k = 0; k < 400 && (commits[0] - c) < 11; k++) tick();
        check("rst_mid_reached", commits[0] - c, 11);
        reset_n = 1'b0;
        #1;
        check("rst_mid_wr", wr[0], 0);
        check("rst_mid_busy", busy[0], 0);
        check("rst_mid_ready", cmd_ready[0], 0);
        for (int g = 0; g < N; g++) wp[g] = rp[g];
        repeat (3) tick();
        for (k = 0; k < 40 && !m2[0]; k++) tick();
        check("rst_m2_high", m2[0], 1);
        reset_n = 1'b1;
        tick();
        check("rst_release_wr", wr[0], 0);
        check("rst_release_ready", cmd_ready[0], 1);
        c = commits[0];
        issue(0, 2'd0, 8'h8A, 8'h3C, 20, acc);
        wait_idle(0, 100, bc);
        check("post_rst_commits", commits[0] - c, 1);
        check("post_rst_write", {last_addr[0], last_data[0]}, {16'h408A, 8'h3C});

        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fds_reg_sequencer.md
Name: fds_reg_sequencer

Overview:
- Bus-side initiator for the FDS audio register file (0x4040–0x408A).
- Accepts host commands and drives the wr/addr/data write port.
- Issues exactly one register write per M2 rising edge.
- Hardware-sequences the two multi-write uploads:
  - 64-entry wavetable: 4089 bit7 gate, writes to 4040–407F.
  - 32-entry mod table: 4087 bit7 halt, 32 writes to 4088.
- Sits between the mapper/loader logic and the FDS audio block, frees the CPU model from cycle-exact upload loops.

Parameters:
- BASE_ADDR, 16'h4000, upper address base OR'd with the 8-bit register offset.
- TBL_RD_LATENCY, 1, clk cycles from tbl_rd_addr to valid tbl_rd_data (legal 1..3).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- m2  in  1  CPU M2 phase; same signal the audio block edge-detects
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  0=single write, 1=wave upload, 2=mod upload, 3=reserved
- cmd_addr  in  8  register offset (op 0 only)
- cmd_data  in  8  op0: write data; op1: final 4089 value; op2: final 4087 value
- tbl_sel  out  1  0=wave table source, 1=mod table source
- tbl_rd_addr  out  6  table source read address
- tbl_rd_data  in  6  table source data (mod uses [2:0])
- busy  out  1  command in progress
- wr  out  1  write strobe to audio block
- addr_out  out  16  write address
- data_out  out  8  write data

Behaviour:
- Reset values: wr=0, addr_out=0, data_out=0, busy=0, tbl_sel=0, tbl_rd_addr=0, state=IDLE, old_m2=1 (so m2 high at release is not a false edge). cmd_ready=0 while reset_n low; 1 in first IDLE cycle after release.
- Edge: edge = m2 & ~old_m2, old_m2 registered every clk.
- Write commit rule:
  - A write is loaded into addr_out/data_out with wr=1.
  - It is held stable until the first clk cycle where edge=1. That cycle is the commit cycle, and wr is high in it.
  - Next write loads at commit+1.
  - A write loaded on an edge cycle does not commit until the following edge.
- Handshake: accept on cmd_valid & cmd_ready. cmd_ready=1 only in IDLE with no write pending. Command fields are latched at accept.
- States and transitions:
  - IDLE → accept → SINGLE (op0), W_EN (op1), M_EN (op2). op3 is accepted and dropped, staying in IDLE.
  - SINGLE: write BASE_ADDR|cmd_addr = cmd_data; after commit → IDLE.
  - W_EN: write 4089 = 8'h80 | cmd_data[1:0]; after commit → W_DATA with index i=0.
  - W_DATA: tbl_sel=0, tbl_rd_addr=i. After TBL_RD_LATENCY cycles, write 4040+i = {2'b00, tbl_rd_data}. After commit, i++; after i=63 commits → W_DIS.
  - W_DIS: write 4089 = {1'b0, 5'b0, cmd_data[1:0]}; after commit → IDLE.
  - M_EN: write 4087 = 8'h80 | cmd_data[3:0]; after commit → M_DATA with i=0.
  - M_DATA: tbl_sel=1, tbl_rd_addr=i (i<32). Write 4088 = {5'b0, tbl_rd_data[2:0]}. After i=31 commits → M_FIN. The 32 writes wrap the audio block's mod pointer back to its start.
  - M_FIN: write 4087 = cmd_data; after commit → IDLE.
- busy=1 in every state except IDLE.
- Table read is issued at commit+1 of the previous write. Data is captured exactly TBL_RD_LATENCY cycles later, then wr is asserted. An M2 period is ≥ 4 clk, so a read never misses an edge.
- Index i is 6 bits with no wrap. Terminal index is 63 (wave) or 31 (mod).
- Write counts:
  - Wave upload: exactly 66 writes (66 M2 edges).
  - Mod upload: exactly 34 writes.
  - Single write: exactly 1.
- Reset mid-upload: aborts immediately and wr drops. The audio block may be left with wave_wren or mod_disable set; the host must reissue the command. No automatic recovery.
- cmd_valid while busy is ignored; the command is held by the host.

Decomposition:
- Shared package fds_pkg:
  - Register offset constants: FDS_WAVE_BASE 8'h40, FDS_MOD_CTRL 8'h87, FDS_MOD_TBL 8'h88, FDS_MASTER 8'h89.
  - cmd_op enum.
  - State enum.
- One sub-module, fds_m2_edge: old_m2 register with reset-to-1, edge output. It is reusable by other M2-timed blocks.

Test Plan:
- Single write: op0, addr 8'h82, data 8'h5A, m2 period 12 clk → one wr commit at next m2 rise, addr_out=16'h4082, data_out=8'h5A; busy high 1..12 clk; cmd_ready back to 1 after commit.
- Wave upload: op1, data 8'h02, table[i]=i ^ 6'h2A → commits in order: 4089=8'h82, then 4040..407F = i^2A, then 4089=8'h02. Exactly 66 commits; audio block wavetable readback matches.
- Mod upload: op2, data 8'h45, table[i]=i[2:0] → 4087=8'h85, 32× 4088 = i[2:0], then 4087=8'h45. Audio mod_accum[17:13] returns to its start value.
- Latency sweep: TBL_RD_LATENCY=3, m2 period 4 clk, wave upload → still 66 commits, no data skew.
- Reset mid-op: assert reset_n=0 after 10 W_DATA commits → wr=0, busy=0 asynchronously. After release with m2 already high, no commit on the first cycle; a new op0 completes normally.
- Reserved and back-pressure: op3 → accepted, zero commits. cmd_valid held during a busy wave upload → accepted only after W_DIS commit.
